// File: rtl/nms_window_ctrl.sv
// Streaming 3x3 NMS window sequencer: two line buffers, registered window, single output stage.
// Optional macro NMS_CORNER_COUNT_EN adds a per-frame corner_count output.
module nms_window_ctrl #(
  parameter int         IMG_W       = 640,
  parameter int         IMG_H       = 480,
  parameter logic [7:0] CORNER_CODE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_score,
  input  logic [7:0]  in_pixel,
  output logic [7:0]  nms_ref_score,
  output logic [63:0] nms_adj_score,
  output logic [7:0]  nms_ref_pixel,
  input  logic [7:0]  nms_out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pixel,
  output logic        out_corner,
  output logic        out_eof
`ifdef NMS_CORNER_COUNT_EN
  ,
  output logic [19:0] corner_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int VW = $clog2(IMG_H + 2);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   col_reg, col_next;
  logic [RW-1:0]   row_reg, row_next;
  logic [15:0]     win_reg [3][2];
  logic [15:0]     col2 [3];
  logic [15:0]     lb0 [IMG_W];
  logic [15:0]     lb1 [IMG_W];
  logic [15:0]     in_word;
  logic            advance, step, eof_beat;
  logic [VW-1:0]   vrow, cen_row;
  logic [CW-1:0]   cen_col;
  logic            border, corner_hit, is_corner;

  assign advance = !out_valid || out_ready;
  assign in_word = (state_reg == FLUSH) ? 16'h0000 : {in_score, in_pixel};

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    step       = 1'b0;
    col_next   = col_reg;
    row_next   = row_reg;
    case (state_reg)
      FILL: begin
        in_ready = advance;
        step     = advance && in_valid;
        if (step && row_reg == RW'(1) && col_reg == '0)
          state_next = RUN;
      end
      RUN: begin
        in_ready = advance;
        step     = advance && in_valid;
        if (step && row_reg == RW'(IMG_H - 1) && col_reg == CW'(IMG_W - 1))
          state_next = FLUSH;
      end
      FLUSH: begin
        step = advance;
        if (advance && row_reg == RW'(1) && col_reg == '0)
          state_next = FILL;
      end
      default: state_next = FILL;
    endcase
    if (step) begin
      if (col_reg == CW'(IMG_W - 1)) begin
        col_next = '0;
        row_next = (row_reg == RW'(IMG_H - 1)) ? '0 : row_reg + RW'(1);
      end else begin
        col_next = col_reg + CW'(1);
      end
      // Leaving FLUSH: the next accepted beat is pixel (0,0) of a new frame.
      if (state_reg == FLUSH && state_next == FILL) begin
        col_next = '0;
        row_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FILL;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
    end
  end

  assign col2[0] = lb1[col_reg];
  assign col2[1] = lb0[col_reg];
  assign col2[2] = in_word;

  always_ff @(posedge clk) begin
    if (step) begin
      lb1[col_reg] <= lb0[col_reg];
      lb0[col_reg] <= in_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= '0;
        win_reg[r][1] <= '0;
      end
    end else if (step) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= win_reg[r][1];
        win_reg[r][1] <= col2[r];
      end
    end
  end

  assign nms_ref_score = win_reg[1][1][15:8];
  assign nms_ref_pixel = win_reg[1][1][7:0];
  assign nms_adj_score = {win_reg[0][0][15:8], win_reg[0][1][15:8], col2[0][15:8],
                          win_reg[1][0][15:8], col2[1][15:8],
                          win_reg[2][0][15:8], win_reg[2][1][15:8], col2[2][15:8]};

  // Flush beats sit on virtual rows IMG_H and IMG_H+1 while the counters restart at row 0.
  assign vrow     = (state_reg == FLUSH) ? VW'(row_reg) + VW'(IMG_H) : VW'(row_reg);
  assign cen_row  = (col_reg == '0) ? vrow - VW'(2) : vrow - VW'(1);
  assign cen_col  = (col_reg == '0) ? CW'(IMG_W - 1) : col_reg - CW'(1);
  assign border   = (cen_row == '0) || (cen_row == VW'(IMG_H - 1)) ||
                    (cen_col == '0) || (cen_col == CW'(IMG_W - 1));
  assign eof_beat = (state_reg == FLUSH) && row_reg == RW'(1) && col_reg == '0;

  always_comb begin
    corner_hit = 1'b0;
    if (nms_out_pixel == CORNER_CODE)
      corner_hit = 1'b1;
  end
  assign is_corner = corner_hit && !border;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_corner <= 1'b0;
      out_eof    <= 1'b0;
    end else if (advance) begin
      out_valid <= step && (state_reg != FILL);
      if (step && state_reg != FILL) begin
        out_pixel  <= is_corner ? 8'hFF : nms_ref_pixel;
        out_corner <= is_corner;
        out_eof    <= eof_beat;
      end
    end
  end

`ifdef NMS_CORNER_COUNT_EN
  logic [19:0] corner_acc_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corner_acc_reg <= '0;
      corner_count   <= '0;
    end else if (out_valid && out_ready) begin
      if (out_eof) begin
        corner_count   <= corner_acc_reg + {19'd0, out_corner};
        corner_acc_reg <= '0;
      end else if (out_corner) begin
        corner_acc_reg <= corner_acc_reg + 20'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nms_window_ctrl.sv
// Directed bench for nms_window_ctrl on an 8x6 frame with a behavioural NMS datapath model.
module tb_nms_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_score, in_pixel;
  logic [7:0]  nms_ref_score, nms_ref_pixel, nms_out_pixel;
  logic [63:0] nms_adj_score;
  logic        out_valid, out_ready, out_corner, out_eof;
  logic [7:0]  out_pixel;
`ifdef NMS_CORNER_COUNT_EN
  logic [19:0] corner_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] score_map [N];
  bit         exp_corner [N];
  logic [7:0] cap_pix [N];
  logic       cap_cor [N];
  logic       cap_eof [N];

  nms_window_ctrl #(.IMG_W(W), .IMG_H(H), .CORNER_CODE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score), .in_pixel(in_pixel),
    .nms_ref_score(nms_ref_score), .nms_adj_score(nms_adj_score),
    .nms_ref_pixel(nms_ref_pixel), .nms_out_pixel(nms_out_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_corner(out_corner), .out_eof(out_eof)
`ifdef NMS_CORNER_COUNT_EN
    , .corner_count(corner_count)
`endif
  );

  always #5 clk = ~clk;

  // Datapath: corner if centre score nonzero and no neighbour strictly greater.
  logic any_gt;
  always_comb begin
    any_gt = 1'b0;
    for (int i = 0; i < 8; i++)
      if (nms_adj_score[i*8 +: 8] > nms_ref_score) any_gt = 1'b1;
    nms_out_pixel = (nms_ref_score != 8'd0 && !any_gt) ? 8'hA5 : nms_ref_pixel;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_maps();
    for (int i = 0; i < N; i++) begin
      score_map[i]  = 8'd0;
      exp_corner[i] = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input bit tog, input int reset_at, input bit chk_lat);
    int sent, ocnt, acc_cyc, out_cyc, loaded;
    bit done_rst;
    sent = 0; ocnt = 0; acc_cyc = -1; out_cyc = -1; done_rst = 1'b0;
    for (int cyc = 0; cyc < 3000 && ocnt < N; cyc++) begin
      @(negedge clk);
      if (reset_at >= 0 && !done_rst && sent == reset_at) begin
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #2;
        reset_n  = 1'b1;
        sent = 0; ocnt = 0; done_rst = 1'b1;
      end
      out_ready = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < N);
      in_score  = 8'd0;
      if (sent < N) in_score = score_map[sent];
      in_pixel  = 8'(sent);
      #1;
      if (sent == N) begin
        loaded = ocnt + int'(out_valid);
        if (loaded < N) check({name, " flush_in_ready"}, 32'(in_ready), 32'd0);
      end
      if (out_valid && !out_ready) check({name, " stall_in_ready"}, 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        cap_pix[ocnt] = out_pixel;
        cap_cor[ocnt] = out_corner;
        cap_eof[ocnt] = out_eof;
        if (ocnt == 19) out_cyc = cyc;
        ocnt++;
      end
      if (in_valid && in_ready) begin
        if (sent == 28) acc_cyc = cyc;
        sent++;
      end
    end
    check({name, " output_count"}, 32'(ocnt), 32'(N));
    for (int j = 0; j < ocnt; j++) begin
      logic [9:0] expw, obsw;
      expw = {(exp_corner[j] ? 8'hFF : 8'(j)), exp_corner[j], (j == N - 1)};
      obsw = {cap_pix[j], cap_cor[j], cap_eof[j]};
      check($sformatf("%s out%0d{pix,corner,eof}", name, j), 32'(obsw), 32'(expw));
    end
    if (chk_lat) check({name, " latency_19"}, 32'(out_cyc - acc_cyc), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_score = 8'd0; in_pixel = 8'd0;
    clear_maps();
    repeat (3) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_pixel", 32'(out_pixel), 32'd0);
    check("rst out_corner", 32'(out_corner), 32'd0);
    check("rst out_eof", 32'(out_eof), 32'd0);
    check("rst ref_score", 32'(nms_ref_score), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
`ifdef NMS_CORNER_COUNT_EN
    check("rst corner_count", 32'(corner_count), 32'd0);
`endif

    // All scores zero: plain raster pass-through.
    clear_maps();
    run_frame("zero", 1'b0, -1, 1'b0);

    // Single interior corner at (2,3) -> output index 19.
    clear_maps();
    score_map[19] = 8'd9; exp_corner[19] = 1'b1;
    run_frame("single", 1'b0, -1, 1'b1);

    // Border candidates at (0,3) and (2,7) are suppressed.
    clear_maps();
    score_map[3] = 8'd9; score_map[23] = 8'd9;
    run_frame("border", 1'b0, -1, 1'b0);

    // Equal neighbours both survive.
    clear_maps();
    score_map[19] = 8'd9; score_map[20] = 8'd9;
    exp_corner[19] = 1'b1; exp_corner[20] = 1'b1;
    run_frame("tie", 1'b0, -1, 1'b0);
`ifdef NMS_CORNER_COUNT_EN
    @(negedge clk);
    check("tie corner_count", 32'(corner_count), 32'd2);
`endif

    // Strictly greater neighbour suppresses the other.
    clear_maps();
    score_map[19] = 8'd9; score_map[20] = 8'd10; exp_corner[20] = 1'b1;
    run_frame("greater", 1'b0, -1, 1'b0);
`ifdef NMS_CORNER_COUNT_EN
    @(negedge clk);
    check("greater corner_count", 32'(corner_count), 32'd1);
`endif

    // Random back-pressure must not change the sequence.
    clear_maps();
    score_map[19] = 8'd9; exp_corner[19] = 1'b1;
    run_frame("stall", 1'b1, -1, 1'b0);

    // Reset after 20 beats, then a clean frame.
    run_frame("midreset", 1'b0, 20, 1'b1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
